// File: rtl/im_sram_port_arbiter.sv
// Round-robin arbiter that shares one item-memory SRAM read port between the GSR, ECG and EEG
// controllers, relocating addresses per modality and steering each returned hypervector by tag.

module im_sram_port_reloc #(
    parameter int LW   = 4,
    parameter int SW   = 8,
    parameter int BASE = 0
) (
    input  logic [LW-1:0] addr_i,
    output logic [SW-1:0] addr_o
);
    assign addr_o = SW'(BASE) + SW'(addr_i);
endmodule

module im_sram_port_arbiter #(
    parameter int HV_DIMENSION    = 32,
    parameter int gsr_addr_width  = 4,
    parameter int ecg_addr_width  = 4,
    parameter int eeg_addr_width  = 5,
    parameter int sram_addr_width = 8,
    parameter int gsr_base        = 0,
    parameter int ecg_base        = 2 ** gsr_addr_width,
    parameter int eeg_base        = 2 ** gsr_addr_width + 2 ** ecg_addr_width,
    parameter int tag_depth       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [gsr_addr_width-1:0]  gsr_addr_i,
    input  logic [ecg_addr_width-1:0]  ecg_addr_i,
    input  logic [eeg_addr_width-1:0]  eeg_addr_i,
    input  logic [2:0]                 req_addr_valid_i,
    output logic [2:0]                 req_addr_ready_o,
    output logic [HV_DIMENSION-1:0]    req_hvout_o,
    output logic [2:0]                 req_hvout_valid_o,
    input  logic [2:0]                 req_hvout_ready_i,
    output logic [sram_addr_width-1:0] sram_addr_o,
    output logic                       sram_addr_valid_o,
    input  logic                       sram_addr_ready_i,
    input  logic [HV_DIMENSION-1:0]    sram_hvin_i,
    input  logic                       sram_hvin_valid_i,
    output logic                       sram_hvin_ready_o,
    output logic                       busy_o,
    output logic                       err_o
);
    localparam int NUM_REQ = 3;
    localparam int PW      = $clog2(tag_depth);

    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]                       state_q, state_d;
    logic [1:0]                       rr_ptr_q, rr_ptr_d;
    logic [1:0]                       hold_id_q, hold_id_d;
    logic [tag_depth-1:0][1:0]        tag_q;
    logic [PW-1:0]                    wptr_q, rptr_q;
    logic [PW:0]                      count_q, count_d;
    logic                             err_q;

    logic [3:0][sram_addr_width-1:0]  reloc;
    logic [3:0]                       vld4, hrdy4;
    logic [1:0]                       grant, head, c1, c2, c3;
    logic                             full, nonempty, push, pop;

    im_sram_port_reloc #(.LW(gsr_addr_width), .SW(sram_addr_width), .BASE(gsr_base))
        u_reloc_gsr (.addr_i(gsr_addr_i), .addr_o(reloc[0]));
    im_sram_port_reloc #(.LW(ecg_addr_width), .SW(sram_addr_width), .BASE(ecg_base))
        u_reloc_ecg (.addr_i(ecg_addr_i), .addr_o(reloc[1]));
    im_sram_port_reloc #(.LW(eeg_addr_width), .SW(sram_addr_width), .BASE(eeg_base))
        u_reloc_eeg (.addr_i(eeg_addr_i), .addr_o(reloc[2]));
    assign reloc[3] = '0;

    // Pad to 4 entries so 2-bit ids always index in range
    assign vld4  = {1'b0, req_addr_valid_i};
    assign hrdy4 = {1'b0, req_hvout_ready_i};

    always_comb begin
        c1 = rr_ptr_q;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        c3 = (c2 == 2'd2) ? 2'd0 : c2 + 2'd1;
        if (state_q == HOLD)  grant = hold_id_q;
        else if (vld4[c1])    grant = c1;
        else if (vld4[c2])    grant = c2;
        else if (vld4[c3])    grant = c3;
        else                  grant = c1;
    end

    assign full              = (count_q == (PW+1)'(tag_depth));
    assign nonempty          = (count_q != '0);
    assign head              = tag_q[rptr_q];

    assign sram_addr_o       = reloc[grant];
    assign sram_addr_valid_o = vld4[grant] && !full;
    assign push              = sram_addr_valid_o && sram_addr_ready_i;

    assign req_hvout_o       = sram_hvin_i;
    assign sram_hvin_ready_o = nonempty && hrdy4[head];
    assign pop               = sram_hvin_valid_i && sram_hvin_ready_o;
    assign busy_o            = nonempty;
    assign err_o             = err_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign req_addr_ready_o[i]  = (grant == 2'(i)) && push;
        assign req_hvout_valid_o[i] = sram_hvin_valid_i && nonempty && (head == 2'(i));
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        hold_id_d = hold_id_q;
        if (push) begin
            state_d  = ARB;
            rr_ptr_d = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
        end else if (state_q == ARB && sram_addr_valid_o) begin
            // Stalled by the SRAM: pin owner and address until the handshake
            state_d   = HOLD;
            hold_id_d = grant;
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            hold_id_q <= '0;
            tag_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_id_q <= hold_id_d;
            count_q   <= count_d;
            if (push) begin
                tag_q[wptr_q] <= grant;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop) rptr_q <= rptr_q + PW'(1);
            if (sram_hvin_valid_i && !nonempty) err_q <= 1'b1;
        end
    end
endmodule

// File: doc/im_sram_port_arbiter.md
# im_sram_port_arbiter

Shares one physical item-memory SRAM read port between the GSR, ECG and EEG memory controllers. Each controller keeps its own address/hypervector handshake pair. The arbiter grants address requests round-robin, relocates each local address into its modality's region of the shared SRAM, and returns every read hypervector to the requester that issued it. It sits between the three memory controllers and a single `HV_DIMENSION`-wide SRAM wrapper.

## Interface
- `gsr_addr_width`, default `GSR_SRAM_ADDR_WIDTH`: local address width of requester 0 (GSR).
- `ecg_addr_width`, default `ECG_SRAM_ADDR_WIDTH`: local address width of requester 1 (ECG).
- `eeg_addr_width`, default `EEG_SRAM_ADDR_WIDTH`: local address width of requester 2 (EEG).
- `sram_addr_width`, default 8: width of the shared SRAM address.
- `gsr_base`, `ecg_base`, `eeg_base`, defaults 0 / 2^`gsr_addr_width` / 2^`gsr_addr_width`+2^`ecg_addr_width`: region base of each requester.
- `tag_depth`, default 4: maximum outstanding reads (power of 2, ≥2).

Ports (index 0 = GSR, 1 = ECG, 2 = EEG):
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `gsr_addr` / `ecg_addr` / `eeg_addr`, in, per-requester width: local read address.
- `req_addr_valid`, in, 3: per-requester address valid.
- `req_addr_ready`, out, 3: per-requester address accepted.
- `req_hvout`, out, `HV_DIMENSION`: returned hypervector, broadcast to all requesters.
- `req_hvout_valid`, out, 3: returned hypervector belongs to requester i.
- `req_hvout_ready`, in, 3: requester i accepts the hypervector.
- `sram_addr`, out, `sram_addr_width`: shared address (base + zero-extended local address).
- `sram_addr_valid`, out, 1: address valid toward the SRAM.
- `sram_addr_ready`, in, 1: SRAM accepts the address.
- `sram_hvin`, in, `HV_DIMENSION`: read data from the SRAM.
- `sram_hvin_valid`, in, 1: read data valid.
- `sram_hvin_ready`, out, 1: arbiter accepts the read data.
- `busy`, out, 1: at least one read is outstanding.
- `err`, out, 1: sticky. Set when read data arrives with no read outstanding.

## Operation
- **State machine**
  - ARB: `grant` is combinational. It is the first valid requester, searching in the order `rr_ptr`, `rr_ptr`+1, `rr_ptr`+2 (mod 3).
  - HOLD: `grant` = `hold_id` (registered).
  - ARB→HOLD: `sram_addr_valid` is high and `sram_addr_ready` is low. `hold_id` is set to `grant`.
  - HOLD→ARB: on the address handshake.
  - Purpose: a stalled request keeps its address and owner stable. A newly arriving requester cannot steal it.
- **Address channel**
  - `sram_addr_valid` = (any `req_addr_valid` in ARB, or `req_addr_valid[hold_id]` in HOLD) and not tag-full.
  - `req_addr_ready[i]` = (i == `grant`) && `sram_addr_ready` && !tag-full.
  - A requester dropping valid while held is a protocol violation. The arbiter stays in HOLD and keeps `sram_addr_valid` low until that requester reasserts valid.
- **Handshake effects.** An address handshake does three things:
  - pushes `grant` into the tag FIFO;
  - sets `rr_ptr` to (`grant`+1) mod 3;
  - pulses the address to the SRAM.
- **Address arithmetic.** `sram_addr` = base[grant] + local address, zero-extended, with modulo-2^`sram_addr_width` wrap. Base/width overlap is not checked in RTL.
- **Return channel**
  - Let `head` be the tag at the FIFO head.
  - `req_hvout` = `sram_hvin` (combinational pass-through).
  - `req_hvout_valid[i]` = `sram_hvin_valid` && count≠0 && `head`==i.
  - `sram_hvin_ready` = count≠0 && `req_hvout_ready[head]`.
  - A return handshake pops the FIFO.
- **Tag FIFO occupancy**
  - `count` range is 0..`tag_depth`.
  - Full (count == `tag_depth`) blocks push, even when a pop happens in the same cycle.
  - Simultaneous push and pop (not full, not empty) leaves `count` unchanged.
  - Read and write pointers wrap modulo `tag_depth`.
- **Error case.** When `sram_hvin_valid` is high and count==0:
  - `sram_hvin_ready` stays 0;
  - `err` is set and stays set until `rst`.
- `busy` = count≠0.

## Timing
- **Reset values.** State ARB, `rr_ptr`=0 (GSR first), count=0, pointers=0, `hold_id`=0, `err`=0. As a result:
  - `sram_addr_valid`, `req_addr_ready`, `req_hvout_valid`, `sram_hvin_ready` and `busy` are all 0.
  - `req_hvout` follows `sram_hvin`.
- **Latency.** Zero added cycles on both channels; all paths are combinational. Tag and pointer updates take effect on the next clock edge.
- **Same-cycle return.** An address handshake and the return of the same read in the same cycle are impossible. The tag becomes visible one cycle after the push. An SRAM returning in the same cycle is unsupported.
- **Fairness.** With all three requesters continuously valid and `sram_addr_ready`=1, grants follow 0,1,2,0,… at one per cycle. A requester's wait is bounded by 2 grants.
- **Reset mid-operation.** Outstanding tags and HOLD are discarded. Returns still in flight afterward set `err`; the surrounding logic must also reset the SRAM.

## Test plan
- **Single request:** `rst`, then ECG valid with `ecg_addr`=3, `ecg_base`=16, SRAM ready → `sram_addr`=19 and `req_addr_ready`=3'b010 the same cycle. A return 2 cycles later → `req_hvout_valid`=3'b010, `busy` 1→0.
- **Round-robin:** all three continuously valid, SRAM always ready → grant sequence 0,1,2,0,1,2. With `tag_depth`=4, push stops after 4 grants until the first return.
- **HOLD stability:** GSR valid and `sram_addr_ready`=0 for 3 cycles, then EEG also valid → `sram_addr` and grant stay on GSR until ready. The next grant goes to ECG/EEG per `rr_ptr`=1.
- **Out-of-order readiness:** tags GSR,EEG outstanding while GSR holds `req_hvout_ready`=0 → `sram_hvin_ready`=0 and EEG gets no data. After GSR accepts, EEG receives the next word.
- **Full with simultaneous pop:** count=4, return handshake plus new valid request in the same cycle → no push that cycle, count=3, push next cycle.
- **Spurious return / reset:** `sram_hvin_valid` with count=0 → `err`=1 and stays 1. `rst` mid-stream with 2 outstanding → count=0, `err`=0, `busy`=0 the next cycle.
